ss_src: RTL
===========

// Module: ss_src
// PURPOSE
//  Source channel downstream of the descriptor controller: one instance per ss slot.
//  Captures descriptor words from the controller's ss_we/ss_adr/ss_dat/ss_dc strobes.
//  Reads the described buffer over its own Wishbone master port into a FIFO, then streams it to the engine.
//  Reports completion on c_done and is released by ss_done or m_reset.
// PARAMETERS
//  FIFO_DEPTH  8   stream FIFO entries (32-bit words); power of 2, >= BURST_LEN
//  BURST_LEN   4   max words per Wishbone burst (cyc/cab held)
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rst_n     in   1   asynchronous active-low reset
//  ss_we        in   1   descriptor word write strobe
//  ss_adr       in   2   descriptor word index (2=buffer addr, 3=length; 0,1 ignored)
//  ss_dat       in   32  descriptor word data
//  ss_dc        in   24  descriptor control; bit0 = channel enable
//  ss_done      in   1   controller release pulse
//  m_reset      in   1   synchronous channel reset from controller
//  c_done       out  1   channel complete (level)
//  ss_err       out  1   bus error seen on this job
//  wbm_cyc_o    out  1   WB cycle
//  wbm_stb_o    out  1   WB strobe
//  wbm_cab_o    out  1   WB burst hint
//  wbm_we_o     out  1   WB write enable, constant 0
//  wbm_sel_o    out  4   WB byte select, 4'b1111 when stb
//  wbm_adr_o    out  32  WB address, [1:0] = 0
//  wbm_dat_i    in   32  WB read data
//  wbm_ack_i    in   1   WB acknowledge
//  wbm_err_i    in   1   WB error
//  wbm_rty_i    in   1   WB retry (treated as wait)
//  src_dat      out  32  stream data (FIFO head)
//  src_valid    out  1   stream data valid
//  src_ready    in   1   stream accept; transfer when valid&ready
// BEHAVIOUR
//  Reset / m_reset:
//   - state IDLE; FIFO flushed; all outputs 0; addr and len regs 0.
//   - m_reset drops cyc/stb the next cycle, including mid-burst; it has priority over every other input.
//  Descriptor load (IDLE only; ignored in any other state):
//   - ss_we & ss_adr==2: addr <= {ss_dat[31:2],2'b00}.
//   - ss_we & ss_adr==3: len <= ss_dat[15:0] in words; state -> ARM.
//  ARM (1 cycle; ss_dc is sampled here):
//   - !ss_dc[0] or len==0: go to DONE; no bus activity.
//   - otherwise go to REQ. ss_err is cleared on entry to ARM.
//  REQ:
//   - Start a burst only when FIFO free >= n, where n = min(BURST_LEN, remaining).
//   - Burst start: cyc=stb=cab=1, sel=1111, adr=addr.
//   - Each ack: push wbm_dat_i, addr += 4 (wraps at 2^32), remaining -= 1.
//   - rty with no ack: hold the cycle and wait.
//   - After n acks: cyc/stb/cab drop in the same edge as the last ack; at least 1 idle cycle before the next burst.
//   - remaining==0 -> DRAIN.
//  DRAIN: when FIFO empty, go to DONE.
//  DONE:
//   - c_done=1 (registered; first asserted the cycle after the last pop).
//   - Held until ss_done; then c_done <= 0 and state -> IDLE.
//  Error: wbm_err_i during an active stb does all of the following:
//   - cyc/stb drop next cycle; FIFO flushed; ss_err=1.
//   - state -> DONE; the word is not pushed.
//   - ss_err holds until the next ARM or reset.
//  Stream: src_valid = !fifo_empty; src_dat = FIFO head, combinational from the storage read pointer.
//  Simultaneous push and pop on the same cycle are both honoured; count stays unchanged.
//  ss_done outside DONE is ignored.
//  Word order on src_dat equals ascending address order.
// TESTING
//  1. addr=0x1000, len=5, dc[0]=1, ready=1.
//     -> bursts of 4 words (0x1000..0x100C) then 1 word (0x1010); 5 words out in order; c_done=1 one cycle after last pop.
//  2. len=12, ready=0, DEPTH=8.
//     -> two 4-word bursts, FIFO full (8 words), no stb while full.
//     -> ready=1 resumes; all 12 words delivered; no overflow.
//  3. len=0, or dc[0]=0.
//     -> no cyc ever; c_done=1 two cycles after the ss_adr=3 write.
//     -> ss_done pulse -> c_done=0 and back to IDLE.
//  4. err on 3rd beat of the first burst.
//     -> cyc=0 next cycle, FIFO empty, ss_err=1, c_done=1.
//     -> next job's ARM clears ss_err.
//  5. m_reset pulse mid-burst.
//     -> cyc/stb=0 next cycle, src_valid=0, c_done=0, IDLE.
//     -> a new descriptor loads normally.
//  6. addr=0xFFFFFFF8, len=4.
//     -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004; ss_we during REQ is ignored.

Source files
------------

// File: rtl/ss_src.sv
// ss_src: source channel for one ss slot. It captures a descriptor (buffer
// address and length), reads the buffer over a Wishbone master port in bursts
// into a small stream FIFO, and presents the words on a valid/ready stream.
// Completion is reported on c_done until the controller releases the channel.
//
// state | meaning
// IDLE  | waiting for descriptor words; only state that accepts ss_we
// ARM   | one cycle to sample ss_dc enable and check for an empty job
// REQ   | issuing Wishbone bursts until every word has been fetched
// DRAIN | all words fetched, waiting for the stream to empty the FIFO
// DONE  | c_done held until the ss_done release pulse
module ss_src #(
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        ss_we,
  input  logic [1:0]  ss_adr,
  input  logic [31:0] ss_dat,
  input  logic [23:0] ss_dc,
  input  logic        ss_done,
  input  logic        m_reset,
  output logic        c_done,
  output logic        ss_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_cab_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [31:0] src_dat,
  output logic        src_valid,
  input  logic        src_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;      // words still to fetch
  logic          cyc_q, cyc_d;
  logic [BW-1:0] beats_q, beats_d;  // acks still owed in the current burst
  logic          c_done_q, c_done_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push, pop, flush;
  logic          fifo_empty, drained, room_ok;
  logic [BW-1:0] burst_n;
  logic [CW-1:0] free_w;
  logic          unused_in;

  assign unused_in = &{1'b0, ss_dc[23:1], wbm_rty_i};

  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && src_ready;
  // FIFO is (or becomes at this edge) empty; lets c_done rise right after the last pop
  assign drained    = fifo_empty || ((count_q == CW'(1)) && pop);
  assign burst_n    = (len_q >= 16'(BURST_LEN)) ? BW'(BURST_LEN) : len_q[BW-1:0];
  assign free_w     = CW'(FIFO_DEPTH) - count_q;
  assign room_ok    = (free_w >= CW'(burst_n));

  // Next-state logic: descriptor capture, burst control, completion and error handling
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cyc_d    = cyc_q;
    beats_d  = beats_q;
    c_done_d = c_done_q;
    err_d    = err_q;
    push     = 1'b0;
    flush    = 1'b0;
    if (m_reset) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      len_d    = '0;
      cyc_d    = 1'b0;
      beats_d  = '0;
      c_done_d = 1'b0;
      err_d    = 1'b0;
      flush    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ss_we && ss_adr == 2'd2) begin
            addr_d = {ss_dat[31:2], 2'b00};
          end else if (ss_we && ss_adr == 2'd3) begin
            len_d   = ss_dat[15:0];
            err_d   = 1'b0;
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          if (!ss_dc[0] || len_q == '0) begin
            state_d  = S_DONE;
            c_done_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (cyc_q) begin
            if (wbm_err_i) begin
              // abandon the job: the erroring word and everything buffered is dropped
              cyc_d    = 1'b0;
              beats_d  = '0;
              flush    = 1'b1;
              err_d    = 1'b1;
              state_d  = S_DONE;
              c_done_d = 1'b1;
            end else if (wbm_ack_i) begin
              push    = 1'b1;
              addr_d  = addr_q + 32'd4;
              len_d   = len_q - 16'd1;
              beats_d = beats_q - BW'(1);
              if (beats_q == BW'(1)) begin
                cyc_d = 1'b0;
              end
            end
          end else if (len_q == '0) begin
            if (drained) begin
              state_d  = S_DONE;
              c_done_d = 1'b1;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (room_ok) begin
            // only start when the whole burst fits, so an ack never meets a full FIFO
            cyc_d   = 1'b1;
            beats_d = burst_n;
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state_d  = S_DONE;
            c_done_d = 1'b1;
          end
        end
        S_DONE: begin
          if (ss_done) begin
            c_done_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cyc_q    <= 1'b0;
      beats_q  <= '0;
      c_done_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cyc_q    <= cyc_d;
      beats_q  <= beats_d;
      c_done_q <= c_done_d;
      err_q    <= err_d;
    end
  end

  // FIFO pointers and occupancy; a flush overrides any push or pop that cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wbm_dat_i;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cab_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wbm_adr_o = addr_q;

  assign src_valid = !fifo_empty;
  assign src_dat   = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign c_done    = c_done_q;
  assign ss_err    = err_q;

endmodule
